// File: rtl/pulse_stretcher_pkg.sv
// Shared types and sizing helpers for the pulse stretcher slice.
package pulse_stretcher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned width_for(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-in / stretched-level-out bundle between the pulse source and the stretcher.
interface pulse_stretcher_if
   import pulse_stretcher_pkg::*;
#(
   parameter int QUEUE_MAX = 3
);
   localparam int PW = width_for(QUEUE_MAX + 1);

   logic          pulse;
   logic          level;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   modport master (output pulse, input level, busy, pending, overflow);
   modport slave  (input pulse, output level, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into fixed-width level windows with a guaranteed gap
// and a saturating pending queue. Define PULSE_STRETCH_RETRIG_EN to retrigger in HIGH.
module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int HIGH_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int QUEUE_MAX   = 3
) (
   input  logic              clk,
   input  logic              reset,
   pulse_stretcher_if.slave  bus
);
   localparam int TW = width_for(max_u(HIGH_CYCLES, GAP_CYCLES));
   localparam int PW = width_for(QUEUE_MAX + 1);
   localparam logic [TW-1:0] T_HIGH = TW'(HIGH_CYCLES - 1);
   localparam logic [TW-1:0] T_GAP  = TW'(GAP_CYCLES - 1);
   localparam logic [PW-1:0] P_MAX  = PW'(QUEUE_MAX);
`ifdef PULSE_STRETCH_RETRIG_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [PW-1:0] pending_q, pending_d;
   logic          level_q, busy_q, overflow_q, overflow_d;
   logic          gap_exit, queue_req;

   assign gap_exit  = (state_q == GAP) && (timer_q == '0);
   assign queue_req = bus.pulse && ((state_q == GAP) || ((state_q == HIGH) && !RETRIG));

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         pending_q  <= '0;
         level_q    <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pending_q  <= pending_d;
         level_q    <= (state_d == HIGH);
         busy_q     <= (state_d != IDLE);
         overflow_q <= overflow_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a latch behind.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         IDLE: begin
            if (bus.pulse) begin
               state_d = HIGH;
               timer_d = T_HIGH;
            end
         end
         HIGH: begin
`ifdef PULSE_STRETCH_RETRIG_EN
            if (bus.pulse) begin
               timer_d = T_HIGH;
            end else if (timer_q == '0) begin
               state_d = GAP;
               timer_d = T_GAP;
            end else begin
               timer_d = timer_q - TW'(1);
            end
`else
            if (timer_q == '0) begin
               state_d = GAP;
               timer_d = T_GAP;
            end else begin
               timer_d = timer_q - TW'(1);
            end
`endif
         end
         GAP: begin
            if (timer_q == '0) begin
               if ((pending_q != '0) || bus.pulse) begin
                  state_d = HIGH;
                  timer_d = T_HIGH;
               end else begin
                  state_d = IDLE;
                  timer_d = '0;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // At GAP exit a pulse replaces the dequeued event, so that edge can never overflow.
   always_comb begin
      pending_d  = pending_q;
      overflow_d = 1'b0;
      if (gap_exit) begin
         if ((pending_q != '0) && !bus.pulse)
            pending_d = pending_q - PW'(1);
      end else if (queue_req) begin
         if (pending_q == P_MAX)
            overflow_d = 1'b1;
         else
            pending_d = pending_q + PW'(1);
      end
   end

   assign bus.level    = level_q;
   assign bus.busy     = busy_q;
   assign bus.pending  = pending_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed + random bench for pulse_stretcher against a window-schedule reference model.
module tb_pulse_stretcher;
   import pulse_stretcher_pkg::*;

   localparam int H = 4;
   localparam int G = 2;
   localparam int Q = 3;
`ifdef PULSE_STRETCH_RETRIG_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pulse_stretcher_if #(.QUEUE_MAX(Q)) bus ();

   pulse_stretcher #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .QUEUE_MAX(Q)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: absolute cycle numbers of the latest window plus a queued-event count.
   int cyc     = 0;
   int m_start = -100;
   int m_end   = -100;
   int m_pend  = 0;
   bit m_ovf   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_start = -100;
      m_end   = -100;
      m_pend  = 0;
      m_ovf   = 1'b0;
   endtask

   // Edge closing cycle e: a window may start at e+1 only once the previous one plus its gap is over.
   task automatic model_edge(input bit p);
      int e;
      e     = cyc;
      m_ovf = 1'b0;
      if ((m_pend > 0 || p) && (e + 1 >= m_end + G + 1)) begin
         m_start = e + 1;
         m_end   = e + H;
         if (m_pend > 0 && !p) m_pend--;
      end else if (p) begin
         if (RETRIG && e >= m_start && e <= m_end) m_end = e + H;
         else if (m_pend == Q)                     m_ovf = 1'b1;
         else                                      m_pend++;
      end
      cyc++;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".level"},    32'(bus.level),    32'(cyc >= m_start && cyc <= m_end));
      check({tag, ".busy"},     32'(bus.busy),     32'(cyc >= m_start && cyc <= m_end + G));
      check({tag, ".pending"},  32'(bus.pending),  32'(m_pend));
      check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".level"},    32'(bus.level),    32'd0);
      check({tag, ".busy"},     32'(bus.busy),     32'd0);
      check({tag, ".pending"},  32'(bus.pending),  32'd0);
      check({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
   endtask

   task automatic step(input bit p, input string tag);
      bus.pulse = p;
      @(posedge clk);
      model_edge(p);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, tag);
   endtask

   bit exp_lvl  [7] = '{1, 1, 1, 1, 0, 0, 0};
   bit exp_busy [7] = '{1, 1, 1, 1, 1, 1, 0};

   initial begin
      bus.pulse = 1'b0;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
      model_reset();
      idle(2, "post_reset");

      // Single pulse with hard timing expectations.
      step(1'b1, "s1");
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step(1'b0, "s1");
         check("s1.level_timing", 32'(bus.level), 32'(exp_lvl[i]));
         check("s1.busy_timing",  32'(bus.busy),  32'(exp_busy[i]));
      end
      idle(2, "s1_tail");

      // Back-to-back pulses: one queued.
      step(1'b1, "s2"); step(1'b1, "s2");
      idle(14, "s2");

      // Five pulses: queue saturates, last one dropped.
      for (int i = 0; i < 5; i++) step(1'b1, "s3");
      idle(28, "s3");

      // Pulse exactly on the GAP-exit edge with empty queue.
      step(1'b1, "s4");
      idle(5, "s4");
      step(1'b1, "s4_gapexit");
      idle(10, "s4");

      // Reset mid-operation.
      step(1'b1, "s5"); step(1'b1, "s5"); step(1'b1, "s5");
      #1 reset = 1'b1;
      #1 check_zero("s5_async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, "s5_fresh");
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step(1'b0, "s5_fresh");
         check("s5.level_timing", 32'(bus.level), 32'(exp_lvl[i]));
      end
      idle(2, "s5_tail");

      // Pulse during HIGH: queued or retriggered depending on build.
      step(1'b1, "s6"); step(1'b0, "s6"); step(1'b1, "s6");
      idle(14, "s6");

      // Random traffic with occasional asynchronous reset.
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 2) == 0, "rand");
         if ($urandom_range(0, 149) == 0) begin
            #2 reset = 1'b1;
            #1 check_zero("rand_reset");
            model_reset();
            #1 reset = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
